pong_btn_cond: RTL and testbench

PONG_BTN_COND -- requirements
Module: pong_btn_cond

---
 rtl/pong_btn_cond.sv | 188 ++++++++++++++++++
 tb/tb_pong_btn_cond.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_btn_cond.sv
// pong_btn_cond: push-button conditioning for the pong game.
// Each of the two buttons passes through a 2-flop synchroniser and then an
// independent 4-state debounce FSM (ZERO, WAIT1, ONE, WAIT0). The debounced
// level drives btn_db, and a one-cycle btn_tick marks every debounced press.
// btn_any is the OR of both tick bits and is registered in the same cycle.
//
// Optional feature: define BTN_AUTOREPEAT_EN to add auto-repeat. A button
// held in ONE then emits an extra tick after REP_DELAY cycles, followed by
// one every REP_PERIOD cycles. Without the macro no repeat counter exists.
//
// Handshake: none. Inputs are free-running level signals and outputs are
// registered levels/pulses. No valid/ready protocol is involved.
//
// dbg_state exposes both FSM states ({fsm1, fsm0}, 2 bits each:
// 0=ZERO, 1=WAIT1, 2=ONE, 3=WAIT0) so that checkers can bind to them.
module pong_btn_cond #(
    parameter int DB_CYCLES  = 250000,
    parameter int CNT_W      = 18,
    parameter int REP_DELAY  = 12500000,
    parameter int REP_PERIOD = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_db,
    output logic [1:0] btn_tick,
    output logic       btn_any,
    output logic [3:0] dbg_state
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // The debounce counter counts DB_CYCLES-1 down to 0. Together with the
    // entry cycle and the 2-flop synchroniser, this yields DB_CYCLES+3 edges
    // from the first sampling edge to the btn_db change.
    localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DB_CYCLES - 1);

    // Parameter sanity checks, evaluated at elaboration time only.
    if (CNT_W < 2 || CNT_W > 31) begin : g_bad_cnt_w
        $error("pong_btn_cond: CNT_W out of range");
    end
    if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_db_cycles
        $error("pong_btn_cond: DB_CYCLES must be in 2..2^CNT_W-1");
    end
    if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_rep
        $error("pong_btn_cond: REP_DELAY and REP_PERIOD must be at least 1");
    end

    logic [1:0]       sync_q1;
    logic [1:0]       sync_q2;
    db_state_t        state  [2];
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       tick_next;

`ifdef BTN_AUTOREPEAT_EN
    // The repeat timing can exceed the debounce counter range (the default
    // REP_DELAY needs 24 bits), so the repeat counter is sized on its own.
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LOAD  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LOAD = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt [2];
`endif

    // Two-flop synchroniser on both pads; nothing downstream sees btn_raw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Per-button debounce FSM. btn_db is set and cleared on the same edges
    // as the ONE/ZERO transitions, so it is a plain flop with no path from
    // btn_raw. The counter only decrements while nonzero, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i]  <= ZERO;
                db_cnt[i] <= '0;
            end
            btn_db <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    ZERO: begin
                        if (sync_q2[i]) begin
                            state[i]  <= WAIT1;
                            db_cnt[i] <= DB_LOAD;
                        end
                    end
                    WAIT1: begin
                        if (!sync_q2[i]) begin
                            state[i] <= ZERO;
                        end else if (db_cnt[i] == '0) begin
                            state[i]  <= ONE;
                            btn_db[i] <= 1'b1;
                        end else begin
                            db_cnt[i] <= db_cnt[i] - 1'b1;
                        end
                    end
                    ONE: begin
                        if (!sync_q2[i]) begin
                            state[i]  <= WAIT0;
                            db_cnt[i] <= DB_LOAD;
                        end
                    end
                    WAIT0: begin
                        if (sync_q2[i]) begin
                            state[i] <= ONE;
                        end else if (db_cnt[i] == '0) begin
                            state[i]  <= ZERO;
                            btn_db[i] <= 1'b0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] - 1'b1;
                        end
                    end
                    default: begin
                        state[i]  <= ZERO;
                        btn_db[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timer: reloaded to REP_DELAY-1 whenever the FSM is not staying
    // in ONE (this includes the ONE->WAIT0->ONE bounce path). While held,
    // it reloads to REP_PERIOD-1 each time it fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state[i] != ONE || !sync_q2[i]) begin
                    rep_cnt[i] <= REP_DELAY_LOAD;
                end else if (rep_cnt[i] == '0) begin
                    rep_cnt[i] <= REP_PERIOD_LOAD;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] - 1'b1;
                end
            end
        end
    end
`endif

    // Tick request: the WAIT1->ONE transition, plus repeat expiries when the
    // auto-repeat feature is built in. A release never requests a tick.
    always_comb begin
        tick_next = '0;
        for (int i = 0; i < 2; i++) begin
            if (state[i] == WAIT1 && sync_q2[i] && db_cnt[i] == '0) begin
                tick_next[i] = 1'b1;
            end
`ifdef BTN_AUTOREPEAT_EN
            if (state[i] == ONE && sync_q2[i] && rep_cnt[i] == '0) begin
                tick_next[i] = 1'b1;
            end
`endif
        end
    end

    // Registered pulse outputs; btn_any is aligned with btn_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_tick <= '0;
            btn_any  <= 1'b0;
        end else begin
            btn_tick <= tick_next;
            btn_any  <= |tick_next;
        end
    end

    assign dbg_state = {state[1], state[0]};

endmodule

// File: tb/tb_pong_btn_cond.sv
// tb_pong_btn_cond: bench for pong_btn_cond with DB_CYCLES=4, REP_DELAY=10,
// REP_PERIOD=5. Uses a directed vector table, hand-written multi-cycle
// sequences, and randomized button activity scored against a run-length
// reference model.
module tb_pong_btn_cond;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_db;
    logic [1:0] btn_tick;
    logic       btn_any;
    logic [3:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    pong_btn_cond #(
        .DB_CYCLES (DB),
        .CNT_W     (18),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_db   (btn_db),
        .btn_tick (btn_tick),
        .btn_any  (btn_any),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Per button: the synced value is btn_raw two edges back. The debounced
    // level flips once the synced value has differed from it for DB+1
    // consecutive edges. held counts consecutive edges spent stably in the
    // debounced-high state with the input still high. It is used for repeats.
    logic [1:0] m_h1, m_h2, m_db, m_tick;
    int         m_run  [2];
    int         m_held [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_h1 = '0;
            m_h2 = '0;
            m_db = '0;
            m_tick = '0;
            for (int b = 0; b < 2; b++) begin
                m_run[b]  = 0;
                m_held[b] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                logic s;
                s = m_h2[b];
                m_tick[b] = 1'b0;
                if (s != m_db[b]) begin
                    m_held[b] = 0;
                    m_run[b]  = m_run[b] + 1;
                    if (m_run[b] == DB + 1) begin
                        m_db[b]   = s;
                        m_run[b]  = 0;
                        m_tick[b] = s;
                    end
                end else begin
                    if (m_run[b] == 0 && m_db[b]) begin
                        m_held[b] = m_held[b] + 1;
`ifdef BTN_AUTOREPEAT_EN
                        if (m_held[b] >= RD && ((m_held[b] - RD) % RP) == 0)
                            m_tick[b] = 1'b1;
`endif
                    end else begin
                        m_held[b] = 0;
                    end
                    m_run[b] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = btn_raw;
        end
    end

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [1:0] db;
        logic [1:0] tick;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] raw, input logic [1:0] db,
                       input logic [1:0] tick, input logic any, input int n);
        vec_t v;
        v.rst = rst; v.raw = raw; v.db = db; v.tick = tick; v.any = any;
        repeat (n) vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_db(input logic [1:0] want, input string name);
        int k;
        for (k = 0; k < 30; k++) begin
            if (btn_db == want) break;
            cycle();
        end
        check(name, {30'd0, btn_db}, {30'd0, want});
    endtask

    int first_e, n_tick, n_any, rise_seen;
    logic [1:0] first_val;
    int got_off[$];
    int exp_off[$];
    int hold0, hold1;

    initial begin
        reset   = 1'b1;
        btn_raw = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {25'd0, btn_db, btn_tick, btn_any, dbg_state},
              32'd0);
        reset = 1'b0;

        // Table: clean press, glitch, simultaneous press, bounce,
        // simultaneous release, reset in WAIT1 with button held.
        add(0, 2'b01, 2'b00, 2'b00, 0, 6);
        add(0, 2'b01, 2'b01, 2'b01, 1, 1);   // edge 7: press lands
        add(0, 2'b01, 2'b01, 2'b00, 0, 2);
        add(0, 2'b10, 2'b01, 2'b00, 0, 3);   // btn1 glitch 3 cycles, btn0 released
        add(0, 2'b00, 2'b01, 2'b00, 0, 3);
        add(0, 2'b00, 2'b00, 2'b00, 0, 3);   // btn0 falls 7 edges after release
        add(0, 2'b11, 2'b00, 2'b00, 0, 6);   // both pressed together
        add(0, 2'b11, 2'b11, 2'b11, 1, 1);
        add(0, 2'b11, 2'b11, 2'b00, 0, 2);
        add(0, 2'b10, 2'b11, 2'b00, 0, 2);   // btn0 bounces low 2 cycles
        add(0, 2'b11, 2'b11, 2'b00, 0, 3);
        add(0, 2'b00, 2'b11, 2'b00, 0, 6);   // both released
        add(0, 2'b00, 2'b00, 2'b00, 0, 3);
        add(0, 2'b01, 2'b00, 2'b00, 0, 3);   // into WAIT1
        add(1, 2'b01, 2'b00, 2'b00, 0, 2);   // reset mid-debounce
        add(0, 2'b01, 2'b00, 2'b00, 0, 6);
        add(0, 2'b01, 2'b01, 2'b01, 1, 1);   // full debounce after release
        add(0, 2'b01, 2'b01, 2'b00, 0, 2);
        add(0, 2'b00, 2'b01, 2'b00, 0, 6);
        add(0, 2'b00, 2'b00, 2'b00, 0, 3);

        for (int r = 0; r < vecs.size(); r++) begin
            reset   = vecs[r].rst;
            btn_raw = vecs[r].raw;
            cycle();
            check($sformatf("vec_row%0d", r + 1),
                  {27'd0, btn_db, btn_tick, btn_any},
                  {27'd0, vecs[r].db, vecs[r].tick, vecs[r].any});
        end

        // Sequence: asynchronous reset with both buttons held, then release.
        btn_raw = 2'b11;
        wait_db(2'b11, "seq_rst_setup");
        #2 reset = 1'b1;
        #1 check("async_rst_clear", {25'd0, btn_db, btn_tick, btn_any, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        first_e = 0; first_val = '0; n_tick = 0; n_any = 0;
        for (int e = 1; e <= 15; e++) begin
            cycle();
            if (btn_tick != 2'b00) begin
                n_tick++;
                if (first_e == 0) begin
                    first_e   = e;
                    first_val = btn_tick;
                end
            end
            if (btn_any) n_any++;
        end
        check("rst_release_tick_edge", first_e, 7);
        check("rst_release_tick_val", {30'd0, first_val}, 32'd3);
        check("rst_release_tick_count", n_tick, 1);
        check("rst_release_any_count", n_any, 1);

        // Sequence: long hold of btn0, recording tick offsets from btn_db rise.
        btn_raw = 2'b00;
        wait_db(2'b00, "seq_hold_idle");
        cycle();
        btn_raw = 2'b01;
        rise_seen = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (btn_db[0]) begin
                rise_seen = 1;
                break;
            end
        end
        check("hold_rise_seen", rise_seen, 1);
        got_off.delete();
        if (btn_tick[0]) got_off.push_back(0);
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (btn_tick[0]) got_off.push_back(k);
        end
        exp_off.delete();
        exp_off.push_back(0);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = RD; k <= 40; k += RP) exp_off.push_back(k);
`endif
        check("hold_tick_count", got_off.size(), exp_off.size());
        for (int j = 0; j < exp_off.size(); j++) begin
            check($sformatf("hold_tick_off%0d", j),
                  (j < got_off.size()) ? got_off[j] : -1, exp_off[j]);
        end
        btn_raw = 2'b00;

        // Randomized activity against the reference model.
        @(negedge clk);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        hold0 = 0;
        hold1 = 0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if (hold0 == 0) begin
                btn_raw[0] = $urandom_range(0, 1);
                hold0 = $urandom_range(1, 30);
            end
            if (hold1 == 0) begin
                btn_raw[1] = $urandom_range(0, 1);
                hold1 = $urandom_range(1, 30);
            end
            hold0--;
            hold1--;
            cycle();
            exp_q.push_back({m_db, m_tick, |m_tick});
            check($sformatf("rand_c%0d", c), {27'd0, btn_db, btn_tick, btn_any},
                  {27'd0, exp_q.pop_front()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
